// File: rtl/commit_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | commit_sequencer_pkg                                                       |
// | Shared slot-entry layout and helpers for the in-order commit sequencer.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

// Fallbacks for builds where core.vh is not on the include path.
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 3
`endif
`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif

package commit_sequencer_pkg;

  localparam int c_dest_width     = 4;
  localparam int c_res_addr_width = 8;

  typedef struct packed {
    logic                        commit_flag;
    logic                        writes_external;
    logic [c_dest_width-1:0]     dest;
    logic [c_res_addr_width-1:0] res_addr;
  } slot_ctrl_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/commit_sequencer_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter                                                                 |
// | One-hot round-robin grant: first requester at or after pointer, wrapping.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  request,
  input  logic [PW-1:0] pointer,
  output logic [N-1:0]  grant
);

  logic w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    // Upper segment first, then wrap around to the indices below the pointer.
    for (int i = 0; i < N; i++) begin
      if (!w_found && request[i] && (i >= int'(pointer))) begin
        grant[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && request[i]) begin
        grant[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/commit_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | commit_sequencer                                                           |
// | Merges out-of-order branch results into an in-order writeback stream.     |
// | Optional feature: COMMIT_SEQ_OVERRUN_EN adds overrun / overrun_count.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 3
`endif
`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif

module commit_sequencer
  import commit_sequencer_pkg::*;
#(
  parameter int data_width = 16,
  parameter int n_blocks   = 256,
  parameter int n_branches = `N_INSTR_BRANCHES,
  parameter int cid_width  = `COMMIT_ID_WIDTH,
  localparam int BW        = $clog2(n_blocks)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             sample_tick,
  input  logic [n_branches-1:0]            in_valid,
  output logic [n_branches-1:0]            in_ready,
  input  logic [n_branches*cid_width-1:0]  in_commit_id,
  input  logic [n_branches-1:0]            in_commit_flag,
  input  logic [n_branches*BW-1:0]         in_block,
  input  logic [n_branches*4-1:0]          in_dest,
  input  logic [n_branches*data_width-1:0] in_data,
  input  logic [n_branches*8-1:0]          in_res_addr,
  input  logic [n_branches-1:0]            in_writes_external,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BW-1:0]                    out_block,
  output logic [3:0]                       out_dest,
  output logic [data_width-1:0]            out_data,
  output logic [7:0]                       out_res_addr,
  output logic                             out_writes_external,
`ifdef COMMIT_SEQ_OVERRUN_EN
  output logic                             overrun,
  output logic [7:0]                       overrun_count,
`endif
  output logic                             idle
);

  localparam int c_depth = 2 ** cid_width;
  localparam int c_pw    = ptr_width(n_branches);

  logic [c_depth-1:0]    r_occ;
  slot_ctrl_t            r_ctrl  [c_depth];
  logic [BW-1:0]         r_block [c_depth];
  logic [data_width-1:0] r_data  [c_depth];
  logic [cid_width-1:0]  r_expected_id;
  logic [c_pw-1:0]       r_rr_ptr;
  logic                  r_out_valid;
  slot_ctrl_t            r_out_ctrl;
  logic [BW-1:0]         r_out_block;
  logic [data_width-1:0] r_out_data;

  logic [n_branches-1:0] w_request;
  logic [n_branches-1:0] w_grant;
  logic                  w_accept_ok;
  logic                  w_accept;
  logic                  w_retire;
  logic [cid_width-1:0]  w_acc_id;
  logic [c_pw-1:0]       w_acc_idx;
  slot_ctrl_t            w_acc_ctrl;
  logic [BW-1:0]         w_acc_block;
  logic [data_width-1:0] w_acc_data;
  logic [c_depth-1:0]    w_occ_next;
  logic [cid_width-1:0]  w_exp_next;
  logic                  w_head_new;
  slot_ctrl_t            w_head_ctrl;
  logic [BW-1:0]         w_head_block;
  logic [data_width-1:0] w_head_data;
  logic                  w_out_valid_next;

  // A branch may only compete when the slot its id names is free.
  for (genvar i = 0; i < n_branches; i++) begin : g_request
    assign w_request[i] = in_valid[i] && !r_occ[in_commit_id[i*cid_width +: cid_width]];
  end

  rr_arbiter #(
    .N  (n_branches),
    .PW (c_pw)
  ) u_rr_arbiter (
    .request (w_request),
    .pointer (r_rr_ptr),
    .grant   (w_grant)
  );

  assign w_accept_ok = enable && !reset && !sample_tick;
  assign w_accept    = w_accept_ok && (|w_grant);
  assign in_ready    = w_accept_ok ? w_grant : '0;

  always_comb begin
    w_acc_id    = '0;
    w_acc_idx   = '0;
    w_acc_ctrl  = '0;
    w_acc_block = '0;
    w_acc_data  = '0;
    for (int i = 0; i < n_branches; i++) begin
      if (w_grant[i]) begin
        w_acc_id                   = in_commit_id[i*cid_width +: cid_width];
        w_acc_idx                  = c_pw'(i);
        w_acc_ctrl.commit_flag     = in_commit_flag[i];
        w_acc_ctrl.writes_external = in_writes_external[i];
        w_acc_ctrl.dest            = in_dest[i*4 +: 4];
        w_acc_ctrl.res_addr        = in_res_addr[i*8 +: 8];
        w_acc_block                = in_block[i*BW +: BW];
        w_acc_data                 = in_data[i*data_width +: data_width];
      end
    end
  end

  // out_valid always mirrors "head slot occupied with commit_flag 1", so a
  // silent (flag 0) head retires without any handshake.
  assign w_retire = (r_out_valid && out_ready) ||
                    (r_occ[r_expected_id] && !r_ctrl[r_expected_id].commit_flag);

  always_comb begin
    w_occ_next = r_occ;
    w_exp_next = r_expected_id;
    if (w_retire) begin
      w_occ_next[r_expected_id] = 1'b0;
      w_exp_next                = r_expected_id + 1'b1;
    end
    if (w_accept) begin
      w_occ_next[w_acc_id] = 1'b1;
    end
    // Bypass the incoming entry so a head-of-line accept shows next cycle.
    w_head_new       = w_accept && (w_acc_id == w_exp_next);
    w_head_ctrl      = w_head_new ? w_acc_ctrl  : r_ctrl[w_exp_next];
    w_head_block     = w_head_new ? w_acc_block : r_block[w_exp_next];
    w_head_data      = w_head_new ? w_acc_data  : r_data[w_exp_next];
    w_out_valid_next = w_occ_next[w_exp_next] && w_head_ctrl.commit_flag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ         <= '0;
      r_expected_id <= '0;
      r_rr_ptr      <= '0;
      r_out_valid   <= 1'b0;
    end else if (enable) begin
      if (sample_tick) begin
        r_occ         <= '0;
        r_expected_id <= '0;
        r_out_valid   <= 1'b0;
      end else begin
        r_occ         <= w_occ_next;
        r_expected_id <= w_exp_next;
        r_out_valid   <= w_out_valid_next;
        if (w_accept) begin
          r_rr_ptr <= (w_acc_idx == c_pw'(n_branches - 1)) ? '0 : w_acc_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept_ok) begin
      if (w_accept) begin
        r_ctrl[w_acc_id]  <= w_acc_ctrl;
        r_block[w_acc_id] <= w_acc_block;
        r_data[w_acc_id]  <= w_acc_data;
      end
      r_out_ctrl  <= w_head_ctrl;
      r_out_block <= w_head_block;
      r_out_data  <= w_head_data;
    end
  end

  assign out_valid           = r_out_valid;
  assign out_block           = r_out_block;
  assign out_dest            = r_out_ctrl.dest;
  assign out_data            = r_out_data;
  assign out_res_addr        = r_out_ctrl.res_addr;
  assign out_writes_external = r_out_ctrl.writes_external;
  assign idle                = ~(|r_occ);

`ifdef COMMIT_SEQ_OVERRUN_EN
  logic       r_overrun;
  logic [7:0] r_overrun_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun       <= 1'b0;
      r_overrun_count <= '0;
    end else if (enable) begin
      r_overrun <= sample_tick && (|r_occ);
      if (sample_tick && (|r_occ) && (r_overrun_count != 8'hFF)) begin
        r_overrun_count <= r_overrun_count + 8'd1;
      end
    end
  end

  assign overrun       = r_overrun;
  assign overrun_count = r_overrun_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_commit_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_commit_sequencer                                                        |
// | Directed scenarios plus random traffic against a slot-level reference.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_commit_sequencer;

  localparam int DW = 16, NBLK = 256, BW = 8, NB = 4, CID = 3, DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset, enable, sample_tick, out_ready;
  logic [NB-1:0]     in_valid, in_ready, in_commit_flag, in_writes_external;
  logic [NB*CID-1:0] in_commit_id;
  logic [NB*BW-1:0]  in_block;
  logic [NB*4-1:0]   in_dest;
  logic [NB*DW-1:0]  in_data;
  logic [NB*8-1:0]   in_res_addr;
  logic              out_valid, out_writes_external, idle;
  logic [BW-1:0]     out_block;
  logic [3:0]        out_dest;
  logic [DW-1:0]     out_data;
  logic [7:0]        out_res_addr;
`ifdef COMMIT_SEQ_OVERRUN_EN
  logic              overrun;
  logic [7:0]        overrun_count;
  logic              m_ovr;
  int                m_ovr_cnt;
`endif

  commit_sequencer #(
    .data_width (DW), .n_blocks (NBLK), .n_branches (NB), .cid_width (CID)
  ) dut (
    .clk (clk), .reset (reset), .enable (enable), .sample_tick (sample_tick),
    .in_valid (in_valid), .in_ready (in_ready), .in_commit_id (in_commit_id),
    .in_commit_flag (in_commit_flag), .in_block (in_block), .in_dest (in_dest),
    .in_data (in_data), .in_res_addr (in_res_addr),
    .in_writes_external (in_writes_external),
    .out_valid (out_valid), .out_ready (out_ready), .out_block (out_block),
    .out_dest (out_dest), .out_data (out_data), .out_res_addr (out_res_addr),
    .out_writes_external (out_writes_external),
`ifdef COMMIT_SEQ_OVERRUN_EN
    .overrun (overrun), .overrun_count (overrun_count),
`endif
    .idle (idle)
  );

  always #5 clk = ~clk;

  // Reference: one record per commit id plus the id due next.
  logic          m_occ   [DEPTH];
  logic          m_flag  [DEPTH];
  logic          m_ext   [DEPTH];
  logic [BW-1:0] m_block [DEPTH];
  logic [3:0]    m_dest  [DEPTH];
  logic [DW-1:0] m_data  [DEPTH];
  logic [7:0]    m_res   [DEPTH];
  int            m_exp, m_ptr, m_last_g;
  logic [DW-1:0] dut_log[$];
  int            tests_run, tests_failed;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] log_at(input int i);
    if (i < dut_log.size()) return dut_log[i];
    return '0;
  endfunction

  function automatic int id_of(input int b);
    return int'(in_commit_id[b*CID +: CID]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_occ[i] = 1'b0;
    m_exp = 0;
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_commit_id = '0; in_commit_flag = '0; in_block = '0;
    in_dest = '0; in_data = '0; in_res_addr = '0; in_writes_external = '0;
  endtask

  task automatic put(input int b, input int id, input logic flag, input logic [DW-1:0] d);
    in_valid[b]               = 1'b1;
    in_commit_id[b*CID +: CID] = CID'(id % DEPTH);
    in_commit_flag[b]         = flag;
    in_data[b*DW +: DW]       = d;
    in_block[b*BW +: BW]      = d[7:0] ^ 8'(b * 37);
    in_dest[b*4 +: 4]         = d[11:8];
    in_res_addr[b*8 +: 8]     = d[15:8] ^ 8'h5A;
    in_writes_external[b]     = d[0];
  endtask

  // One clock: check DUT at negedge against the reference, then advance it.
  task automatic step();
    int g, b, id;
    logic any, exp_ov;
    logic [NB-1:0] exp_ready;
    @(negedge clk);
    g = -1;
    any = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (m_occ[i]) any = 1'b1;
    if (!reset && enable && !sample_tick) begin
      for (int k = 0; k < NB; k++) begin
        b = (m_ptr + k) % NB;
        if (g < 0 && in_valid[b] && !m_occ[id_of(b)]) g = b;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_eq("in_ready", in_ready, exp_ready);
    exp_ov = m_occ[m_exp] && m_flag[m_exp];
    check_eq("out_valid", out_valid, exp_ov);
    check_eq("idle", idle, !any);
    if (exp_ov) begin
      check_eq("out_data", out_data, m_data[m_exp]);
      check_eq("out_fields", {out_block, out_dest, out_res_addr, out_writes_external},
               {m_block[m_exp], m_dest[m_exp], m_res[m_exp], m_ext[m_exp]});
    end
`ifdef COMMIT_SEQ_OVERRUN_EN
    check_eq("overrun", overrun, m_ovr);
    check_eq("overrun_count", overrun_count, m_ovr_cnt[7:0]);
`endif
    if (out_valid && out_ready && enable && !reset && !sample_tick) dut_log.push_back(out_data);
    m_last_g = -1;
    if (reset) begin
      model_clear();
      m_ptr = 0;
`ifdef COMMIT_SEQ_OVERRUN_EN
      m_ovr = 1'b0;
      m_ovr_cnt = 0;
`endif
    end else if (enable) begin
`ifdef COMMIT_SEQ_OVERRUN_EN
      m_ovr = sample_tick && any;
      if (sample_tick && any && m_ovr_cnt < 255) m_ovr_cnt++;
`endif
      if (sample_tick) begin
        model_clear();
      end else begin
        if ((exp_ov && out_ready) || (m_occ[m_exp] && !m_flag[m_exp])) begin
          m_occ[m_exp] = 1'b0;
          m_exp = (m_exp + 1) % DEPTH;
        end
        if (g >= 0) begin
          id = id_of(g);
          m_occ[id]   = 1'b1;
          m_flag[id]  = in_commit_flag[g];
          m_ext[id]   = in_writes_external[g];
          m_block[id] = in_block[g*BW +: BW];
          m_dest[id]  = in_dest[g*4 +: 4];
          m_data[id]  = in_data[g*DW +: DW];
          m_res[id]   = in_res_addr[g*8 +: 8];
          m_ptr       = (g + 1) % NB;
          m_last_g    = g;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    repeat (n) step();
  endtask

  task automatic tick();
    idle_inputs();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    dut_log.delete();
  endtask

  // Keep presented branches valid until the reference says they were granted.
  task automatic hold_until_granted(input int budget, output int cycles);
    cycles = 0;
    for (int t = 0; t < budget && in_valid != '0; t++) begin
      step();
      cycles++;
      if (m_last_g >= 0) in_valid[m_last_g] = 1'b0;
    end
    check_eq("grant_budget", in_valid, '0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    tests_run = 0; tests_failed = 0;
    reset = 1'b1; enable = 1'b1; sample_tick = 1'b0; out_ready = 1'b1;
    idle_inputs();
    model_clear(); m_ptr = 0; m_last_g = -1;
`ifdef COMMIT_SEQ_OVERRUN_EN
    m_ovr = 1'b0; m_ovr_cnt = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;
    check_eq("reset_idle", idle, 1'b1);
    check_eq("reset_out_valid", out_valid, 1'b0);

    // In-order ids on one branch, each written one cycle after accept.
    put(0, 0, 1'b1, 16'h0011); step();
    put(0, 1, 1'b1, 16'h0022); step();
    put(0, 2, 1'b1, 16'h0033); step();
    drain(3);
    check_eq("seq_count", dut_log.size(), 3);
    check_eq("seq_order", {log_at(0), log_at(1), log_at(2)}, 48'h0011_0022_0033);

    // Out-of-order arrival is held until the head id shows up.
    tick();
    put(1, 1, 1'b1, 16'h1111); step();
    drain(3);
    check_eq("ooo_early", dut_log.size(), 0);
    put(0, 0, 1'b1, 16'h0AAA); step();
    drain(4);
    check_eq("ooo_count", dut_log.size(), 2);
    check_eq("ooo_order", {log_at(0), log_at(1)}, 32'h0AAA_1111);

    // All branches at once: one grant per cycle, written in id order.
    tick();
    for (int i = 0; i < NB; i++) put(i, i, 1'b1, DW'(32'hA000 + i * 257));
    hold_until_granted(3 * NB, cyc);
    check_eq("rotate_cycles", cyc, NB);
    drain(4);
    check_eq("rotate_count", dut_log.size(), NB);
    for (int i = 0; i < NB; i++) check_eq("rotate_data", log_at(i), DW'(32'hA000 + i * 257));

    // Silent retire of id 0 lets id 1 through and moves the head to id 2.
    tick();
    put(2, 0, 1'b0, 16'h0BAD);
    put(3, 1, 1'b1, 16'h7FFF);
    hold_until_granted(6, cyc);
    drain(4);
    check_eq("silent_count", dut_log.size(), 1);
    check_eq("silent_data", log_at(0), 16'h7FFF);
    put(0, 2, 1'b1, 16'h2222); step();
    drain(3);
    check_eq("silent_next", {log_at(1), 16'(dut_log.size())}, {16'h2222, 16'd2});

    // Frame tick with stalled entries flushes them.
    tick();
    out_ready = 1'b0;
    put(0, 0, 1'b1, 16'h3030); step();
    put(0, 1, 1'b1, 16'h3131); step();
    drain(2);
    check_eq("held_busy", idle, 1'b0);
    tick();
    check_eq("tick_idle", idle, 1'b1);
    check_eq("tick_out_valid", out_valid, 1'b0);
`ifdef COMMIT_SEQ_OVERRUN_EN
    check_eq("tick_overrun", overrun, 1'b1);
`endif
    out_ready = 1'b1;
    drain(2);

    // Wrap: head at DEPTH-1, then id 0; a duplicate id 0 waits for its slot.
    for (int i = 0; i < DEPTH - 1; i++) begin
      put(0, i, 1'b0, DW'(i)); step();
    end
    drain(3);
    out_ready = 1'b0;
    put(0, DEPTH - 1, 1'b1, 16'hE777); step();
    put(0, 0, 1'b1, 16'hE000); step();
    idle_inputs();
    put(1, 0, 1'b1, 16'hD000);
    repeat (3) begin
      step();
      check_eq("dup_held", in_ready[1], 1'b0);
    end
    out_ready = 1'b1;
    hold_until_granted(8, cyc);
    drain(3);
    check_eq("wrap_count", dut_log.size(), 2);
    check_eq("wrap_order", {log_at(0), log_at(1)}, 32'hE777_E000);
    tick();

    // Reset mid-operation discards buffered entries.
    put(0, 1, 1'b1, 16'h5151); step();
    put(0, 2, 1'b1, 16'h5252); step();
    idle_inputs();
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("rst_idle", idle, 1'b1);
    dut_log.delete();
    put(0, 0, 1'b1, 16'h0C0C); step();
    drain(4);
    check_eq("rst_count", dut_log.size(), 1);
    check_eq("rst_data", log_at(0), 16'h0C0C);

    // Random traffic, ids kept near the head so entries retire regularly.
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 599) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      sample_tick = ($urandom_range(0, 59) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      idle_inputs();
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 1) == 1)
          put(b, m_exp + int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), DW'($urandom));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
